// File: rtl/tstdp_update_ctrl.sv
// Triplet-STDP weight-update sequencer: tracks spike ages, queues pot/dep jobs and services them
// through one shared weight_change datapath and a single-port weight memory. Macro: STDP_WEIGHT_CLAMP_EN.
module tstdp_update_ctrl #(
`ifdef STDP_WEIGHT_CLAMP_EN
    parameter logic [15:0] W_MAX   = 16'hFC00,
`endif
    parameter int          N_SYN   = 8,
    parameter int          IDXW    = 3,
    parameter int          AGE_MAX = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic [N_SYN-1:0] pre_spike_i,
    input  logic             post_spike_i,
    output logic [5:0]       wc_deltat1_o,
    output logic [5:0]       wc_deltat2_o,
    output logic [15:0]      wc_weight_o,
    input  logic [15:0]      wc_weight_i,
    output logic [IDXW-1:0]  mem_addr_o,
    output logic             mem_rd_en_o,
    input  logic [15:0]      mem_rdata_i,
    output logic             mem_wr_en_o,
    output logic [15:0]      mem_wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);
    localparam int         DATA_W  = 16;
    localparam logic [5:0] AGE_SAT = 6'(AGE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WT, S_WR} state_t;
    state_t state, state_nxt;

    logic [5:0]        pre_age [N_SYN];
    logic [5:0]        post_age;
    logic signed [5:0] pot_d1 [N_SYN];
    logic signed [5:0] pot_d2 [N_SYN];
    logic signed [5:0] dep_d1 [N_SYN];
    logic signed [5:0] dep_d2 [N_SYN];
    logic signed [5:0] dep_neg;
    logic [N_SYN-1:0]  pot_pend, dep_pend, pot_set, dep_set, pot_clr, dep_clr;
    logic [N_SYN-1:0]  pot_rem, dep_rem;
    logic [IDXW-1:0]   idx, idx_nxt, ptr, ptr_nxt;
    logic              job_pot, done_nxt, ovf_nxt;

    function automatic logic [5:0] age_inc(input logic [5:0] a);
        return (a >= AGE_SAT) ? AGE_SAT : a + 6'd1;
    endfunction

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] a);
        return (int'(a) == N_SYN - 1) ? '0 : a + 1'b1;
    endfunction

    // First pending index at or after start, wrapping around the synapse range.
    function automatic logic [IDXW-1:0] pick(input logic [N_SYN-1:0] pend, input logic [IDXW-1:0] start);
        logic [IDXW-1:0] sel;
        logic            found;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < N_SYN; k++) begin
            int j;
            j = (int'(start) + k) % N_SYN;
            if (!found && pend[j]) begin
                sel   = IDXW'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

`ifdef STDP_WEIGHT_CLAMP_EN
    function automatic logic [DATA_W-1:0] clamp_w(input logic pot, input logic [DATA_W-1:0] w_init,
                                                  input logic [DATA_W-1:0] w_fin);
        if (pot)
            return (w_fin > W_MAX || w_fin < w_init) ? W_MAX : w_fin;
        return (w_fin > w_init) ? '0 : w_fin;
    endfunction
`endif

    assign dep_neg = $signed(6'd0 - (post_age + 6'd1));
    assign ovf_nxt = |((pot_set & pot_pend) | (dep_set & dep_pend));

    always_comb begin
        pot_set = '0;
        dep_set = '0;
        if (tick_i) begin
            dep_set = pre_spike_i;
            for (int i = 0; i < N_SYN; i++)
                pot_set[i] = post_spike_i && (pre_age[i] < AGE_SAT);
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ptr_nxt   = ptr;
        pot_clr   = '0;
        dep_clr   = '0;
        done_nxt  = 1'b0;
        pot_rem   = pot_pend | pot_set;
        dep_rem   = dep_pend | dep_set;
        case (state)
            S_IDLE: begin
                if (|(pot_pend | dep_pend)) begin
                    idx_nxt   = pick(pot_pend | dep_pend, ptr);
                    state_nxt = S_RD;
                end
            end
            S_RD: state_nxt = S_WT;
            S_WT: state_nxt = S_WR;
            S_WR: begin
                if (job_pot) pot_clr[idx] = 1'b1;
                else         dep_clr[idx] = 1'b1;
                pot_rem = (pot_pend & ~pot_clr) | pot_set;
                dep_rem = (dep_pend & ~dep_clr) | dep_set;
                if (job_pot && dep_rem[idx]) begin
                    state_nxt = S_RD;
                end else begin
                    ptr_nxt = wrap_inc(idx);
                    if (|(pot_rem | dep_rem)) begin
                        idx_nxt   = pick(pot_rem | dep_rem, ptr_nxt);
                        state_nxt = S_RD;
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            ptr          <= '0;
            job_pot      <= 1'b0;
            pot_pend     <= '0;
            dep_pend     <= '0;
            post_age     <= AGE_SAT;
            done_o       <= 1'b0;
            ovf_o        <= 1'b0;
            wc_deltat1_o <= '0;
            wc_deltat2_o <= '0;
            wc_weight_o  <= '0;
            for (int i = 0; i < N_SYN; i++) pre_age[i] <= AGE_SAT;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ptr      <= ptr_nxt;
            done_o   <= done_nxt;
            ovf_o    <= ovf_nxt;
            pot_pend <= (pot_pend & ~pot_clr) | pot_set;
            dep_pend <= (dep_pend & ~dep_clr) | dep_set;
            if (tick_i) begin
                post_age <= post_spike_i ? 6'd0 : age_inc(post_age);
                for (int i = 0; i < N_SYN; i++)
                    pre_age[i] <= pre_spike_i[i] ? 6'd0 : age_inc(pre_age[i]);
            end
            // Job type, deltas and read weight are frozen here and held on wc_* until the next job.
            if (state == S_WT) begin
                job_pot      <= pot_pend[idx];
                wc_deltat1_o <= pot_pend[idx] ? pot_d1[idx] : dep_d1[idx];
                wc_deltat2_o <= pot_pend[idx] ? pot_d2[idx] : dep_d2[idx];
                wc_weight_o  <= mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SYN; i++) begin
            if (pot_set[i]) begin
                pot_d1[i] <= $signed(pre_age[i]);
                pot_d2[i] <= $signed(post_age);
            end
            if (dep_set[i]) begin
                dep_d1[i] <= dep_neg;
                dep_d2[i] <= $signed(pre_age[i]);
            end
        end
    end

    always_comb begin
        mem_wdata_o = '0;
        if (state == S_WR) begin
`ifdef STDP_WEIGHT_CLAMP_EN
            mem_wdata_o = clamp_w(job_pot, wc_weight_o, wc_weight_i);
`else
            mem_wdata_o = wc_weight_i;
`endif
        end
    end

    assign mem_addr_o  = idx;
    assign mem_rd_en_o = (state == S_RD);
    assign mem_wr_en_o = (state == S_WR);
    assign busy_o      = (state != S_IDLE) || (|(pot_pend | dep_pend));

endmodule

// File: tb/tb_tstdp_update_ctrl.sv
// Bench for tstdp_update_ctrl: job-level reference model of ages/pending/round-robin service,
// a toy datapath and a 1-cycle-latency weight memory.
module tb_tstdp_update_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_i = 1'b0;
    logic [7:0]  pre_spike_i = '0;
    logic        post_spike_i = 1'b0;
    logic [5:0]  wc_deltat1_o, wc_deltat2_o;
    logic [15:0] wc_weight_o, wc_weight_i;
    logic [2:0]  mem_addr_o;
    logic        mem_rd_en_o, mem_wr_en_o;
    logic [15:0] mem_rdata_i = '0;
    logic [15:0] mem_wdata_o;
    logic        busy_o, done_o, ovf_o;

    tstdp_update_ctrl dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .pre_spike_i(pre_spike_i), .post_spike_i(post_spike_i),
        .wc_deltat1_o(wc_deltat1_o), .wc_deltat2_o(wc_deltat2_o), .wc_weight_o(wc_weight_o),
        .wc_weight_i(wc_weight_i), .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_rdata_i(mem_rdata_i), .mem_wr_en_o(mem_wr_en_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Toy weight_change datapath shared by the environment and the model.
    function automatic logic [15:0] dp(input logic [15:0] w, input logic [5:0] d1, input logic [5:0] d2);
        logic [15:0] s1, s2;
        s1 = {{10{d1[5]}}, d1};
        s2 = {{10{d2[5]}}, d2};
        return w + (s1 << 4) + s2;
    endfunction
    assign wc_weight_i = dp(wc_weight_o, wc_deltat1_o, wc_deltat2_o);

    logic [15:0] env_mem [8];
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_rdata_i <= env_mem[mem_addr_o];
        if (mem_wr_en_o) env_mem[mem_addr_o] <= mem_wdata_o;
    end

    // Reference model state
    int          m_pre_age [8];
    int          m_post_age;
    bit          m_pot [8];
    bit          m_dep [8];
    int          m_pot_d1 [8], m_pot_d2 [8], m_dep_d1 [8], m_dep_d2 [8];
    int          m_ptr;
    logic [15:0] m_mem [8];
    bit          m_ovf_exp, m_done_exp;
    bit          wr_seen, wr_pot;
    int          wr_idx;
    logic [15:0] wr_val;
    bit          mo_ov, mo_wr;

    function automatic bit any_pend();
        for (int i = 0; i < 8; i++) if (m_pot[i] || m_dep[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int next_idx();
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (m_ptr + k) % 8;
            if (m_pot[j] || m_dep[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pre_age[i] = 31;
                m_pot[i] = 1'b0;
                m_dep[i] = 1'b0;
            end
            m_post_age = 31;
            m_ptr = 0;
            m_ovf_exp = 1'b0;
            m_done_exp = 1'b0;
            wr_seen = 1'b0;
        end else begin
            mo_ov = 1'b0;
            mo_wr = wr_seen;
            if (wr_seen) begin
                if (wr_pot) m_pot[wr_idx] = 1'b0;
                else        m_dep[wr_idx] = 1'b0;
                m_mem[wr_idx] = wr_val;
            end
            if (tick_i) begin
                for (int i = 0; i < 8; i++) begin
                    if (post_spike_i && m_pre_age[i] < 31) begin
                        if (m_pot[i]) mo_ov = 1'b1;
                        m_pot[i] = 1'b1;
                        m_pot_d1[i] = m_pre_age[i];
                        m_pot_d2[i] = m_post_age;
                    end
                    if (pre_spike_i[i]) begin
                        if (m_dep[i]) mo_ov = 1'b1;
                        m_dep[i] = 1'b1;
                        m_dep_d1[i] = -(m_post_age + 1);
                        m_dep_d2[i] = m_pre_age[i];
                    end
                end
                for (int i = 0; i < 8; i++)
                    m_pre_age[i] = pre_spike_i[i] ? 0 : ((m_pre_age[i] < 31) ? m_pre_age[i] + 1 : 31);
                m_post_age = post_spike_i ? 0 : ((m_post_age < 31) ? m_post_age + 1 : 31);
            end
            if (wr_seen) begin
                m_ptr = (wr_pot && m_dep[wr_idx]) ? wr_idx : (wr_idx + 1) % 8;
                wr_seen = 1'b0;
            end
            m_ovf_exp = mo_ov;
            m_done_exp = mo_wr && !any_pend();
        end
    end

    // Per-cycle comparison against the model
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          n_rd = 0, n_wr = 0, n_ovf = 0;
    int          first_rd_cyc = 0, last_wr_cyc = 0, last_done_cyc = 0;
    int          wr_log [$];
    int          cj, cd1, cd2;
    bit          cp;
    logic [15:0] cw, craw, cexp;
    int          lw_d1, lw_d2;
    logic [15:0] lw_data;

    always @(negedge clk) begin
        cyc++;
        if (chk_en && !rst) begin
            chk("busy", busy_o, any_pend());
            chk("done", done_o, m_done_exp);
            chk("ovf", ovf_o, m_ovf_exp);
            if (ovf_o) n_ovf++;
            if (done_o) last_done_cyc = cyc;
            if (mem_rd_en_o) begin
                n_rd++;
                if (n_rd == 1) first_rd_cyc = cyc;
                chk("rd_addr", mem_addr_o, next_idx());
                chk("rd_wr_excl", mem_wr_en_o, 0);
            end
            if (mem_wr_en_o) begin
                n_wr++;
                last_wr_cyc = cyc;
                cj = next_idx();
                chk("wr_has_job", cj >= 0, 1);
                if (cj >= 0) begin
                    cp = m_pot[cj];
                    cd1 = cp ? m_pot_d1[cj] : m_dep_d1[cj];
                    cd2 = cp ? m_pot_d2[cj] : m_dep_d2[cj];
                    cw = m_mem[cj];
                    craw = dp(cw, 6'(cd1), 6'(cd2));
                    cexp = craw;
`ifdef STDP_WEIGHT_CLAMP_EN
                    if (cp) begin
                        if (craw > 16'hFC00 || craw < cw) cexp = 16'hFC00;
                    end else if (craw > cw) begin
                        cexp = 16'h0000;
                    end
`endif
                    chk("wr_addr", mem_addr_o, cj);
                    chk("wr_deltat1", $signed(wc_deltat1_o), cd1);
                    chk("wr_deltat2", $signed(wc_deltat2_o), cd2);
                    chk("wr_weight_init", wc_weight_o, cw);
                    chk("wr_data", mem_wdata_o, cexp);
                    wr_seen = 1'b1;
                    wr_idx = cj;
                    wr_pot = cp;
                    wr_val = cexp;
                    wr_log.push_back(cj);
                    lw_d1 = cd1;
                    lw_d2 = cd2;
                    lw_data = cexp;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input logic [7:0] pre, input logic post);
        step();
        tick_i = 1'b1;
        pre_spike_i = pre;
        post_spike_i = post;
        step();
        tick_i = 1'b0;
        pre_spike_i = '0;
        post_spike_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        step();
        while (busy_o && n < 200) begin
            step();
            n++;
        end
        chk("idle_within_bound", n < 200, 1);
        step();
        step();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int exp_ord [6] = '{0, 3, 7, 0, 3, 7};
    int n;

    initial begin
        for (int i = 0; i < 8; i++) begin
            env_mem[i] = 16'h1000 + 16'(i * 256);
            m_mem[i] = env_mem[i];
        end
        do_reset();
        chk_en = 1'b1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_rd", mem_rd_en_o, 0);
        chk("rst_wr", mem_wr_en_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_d1", wc_deltat1_o, 0);
        chk("rst_weight", wc_weight_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);

        // Quiet ticks: ages saturate, no memory traffic
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < 40; i++) tick(8'h00, 1'b0);
        chk("t1_rd_count", n_rd, 0);
        chk("t1_wr_count", n_wr, 0);
        chk("t1_busy", busy_o, 0);
        chk("t1_model_post_age", m_post_age, 31);

        // Pre spike on syn 2 gives an immediate depression job, then potentiation
        tick(8'h04, 1'b0);
        wait_idle();
        chk("t2_dep_d1", lw_d1, -32);
        chk("t2_dep_d2", lw_d2, 31);
        chk("t2_dep_data", lw_data, 16'h101F);
        for (int i = 0; i < 5; i++) tick(8'h00, 1'b0);
        n_wr = 0;
        tick(8'h00, 1'b1);
        wait_idle();
        chk("t2_wr_count", n_wr, 1);
        chk("t2_pot_addr", wr_log[wr_log.size()-1], 2);
        chk("t2_pot_d1", lw_d1, 5);
        chk("t2_pot_d2", lw_d2, 31);
        chk("t2_pot_data", lw_data, 16'h108E);
        chk("t2_done_latency", last_done_cyc - last_wr_cyc, 1);

        // Depression three ticks after the post spike
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
        tick(8'h04, 1'b0);
        wait_idle();
        chk("t3_dep_d1", lw_d1, -4);
        chk("t3_dep_d2", lw_d2, 9);
        chk("t3_dep_data", lw_data, 16'h1057);

        // Round-robin order over syns 0,3,7
        do_reset();
        wr_log.delete();
        tick(8'h89, 1'b0);
        wait_idle();
        n_rd = 0; n_wr = 0;
        tick(8'h00, 1'b1);
        wait_idle();
        chk("t4_rd_count", n_rd, 3);
        chk("t4_wr_count", n_wr, 3);
        chk("t4_span_cycles", last_wr_cyc - first_rd_cyc + 1, 9);
        chk("t4_done_latency", last_done_cyc - last_wr_cyc, 1);
        chk("t4_log_size", wr_log.size(), 6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++) chk("t4_order", wr_log[k], exp_ord[k]);

        // Back-to-back post spikes overwrite the pending syn-1 job
        do_reset();
        tick(8'h02, 1'b0);
        wait_idle();
        n_wr = 0; n_ovf = 0;
        step();
        tick_i = 1'b1; post_spike_i = 1'b1;
        step();
        step();
        tick_i = 1'b0; post_spike_i = 1'b0;
        wait_idle();
        chk("t5_ovf_count", n_ovf, 1);
        chk("t5_wr_count", n_wr, 1);
        chk("t5_pot_d1", lw_d1, 1);
        chk("t5_pot_d2", lw_d2, 0);

        // Reset during WT aborts the write and drops all pending jobs
        do_reset();
        n_wr = 0;
        tick(8'h50, 1'b0);
        n = 0;
        while (!mem_rd_en_o && n < 20) begin
            step();
            n++;
        end
        chk("t6_rd_seen", mem_rd_en_o, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy_after_rst", busy_o, 0);
        for (int i = 0; i < 5; i++) step();
        chk("t6_wr_count", n_wr, 0);
        chk("t6_busy_still", busy_o, 0);

        // Near-full-scale weight potentiated
        tick(8'h20, 1'b0);
        wait_idle();
        env_mem[5] = 16'hFFF0;
        m_mem[5] = 16'hFFF0;
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b1);
        wait_idle();
        chk("t6_pot_d1", lw_d1, 2);
        chk("t6_pot_d2", lw_d2, 31);
`ifdef STDP_WEIGHT_CLAMP_EN
        chk("t6_clamp_data", lw_data, 16'hFC00);
`else
        chk("t6_raw_data", lw_data, 16'h002F);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
